// File: rtl/uart_axi_bridge.sv
// UART byte-stream command engine driving single-beat AXI-lite bursts (W/R/X commands).
// Optional inter-byte timeout is compiled in with `define UART_AXI_TIMEOUT_EN.
module uart_axi_bridge #(
   parameter int unsigned ADDR_W         = 18,
   parameter int unsigned DATA_W         = 16,
   parameter int unsigned MAX_BURST      = 256,
   parameter int unsigned TIMEOUT_CYCLES = 10000000,
   parameter int unsigned RST_PULSE      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        uart_rx,
   input  logic              uart_rx_valid,
   output logic              uart_rx_ready,
   output logic [7:0]        uart_tx,
   output logic              uart_tx_valid,
   input  logic              uart_tx_ready,
   output logic [ADDR_W-1:0] axi_aw_addr,
   output logic              axi_aw_valid,
   input  logic              axi_aw_ready,
   output logic [DATA_W-1:0] axi_w_data,
   output logic              axi_w_valid,
   input  logic              axi_w_ready,
   input  logic [1:0]        axi_b_resp,
   input  logic              axi_b_valid,
   output logic              axi_b_ready,
   output logic [ADDR_W-1:0] axi_ar_addr,
   output logic              axi_ar_valid,
   input  logic              axi_ar_ready,
   input  logic [DATA_W-1:0] axi_r_data,
   input  logic [1:0]        axi_r_resp,
   input  logic              axi_r_valid,
   output logic              axi_r_ready,
   output logic              axi_resetn,
   output logic              busy
);

   localparam int unsigned AB     = (ADDR_W + 7) / 8;
   localparam int unsigned DB     = (DATA_W + 7) / 8;
   localparam int unsigned TXW    = DB * 8;
   localparam int unsigned CNT_W  = 2;
   localparam int unsigned PCNT_W = $clog2(RST_PULSE + 1);

   localparam logic [7:0] OP_W = 8'h57;
   localparam logic [7:0] OP_R = 8'h52;
   localparam logic [7:0] OP_X = 8'h58;

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_COUNT, S_WDATA, S_AXI_W, S_AXI_B,
      S_AXI_AR, S_AXI_R, S_TXDATA, S_TXSTAT, S_RSTPULSE
   } state_t;

   typedef enum logic [1:0] {ST_KE, ST_QM, ST_TO} stat_t;

   state_t              r_state, w_state_nxt;
   stat_t               r_stat_sel;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [TXW-1:0]      r_rdata_sr;
   logic [CNT_W-1:0]    r_cnt;
   logic [PCNT_W-1:0]   r_pcnt;
   logic [7:0]          r_wleft;
   logic                r_is_wr, r_err;
   logic                r_rx_ready, r_b_ready, r_r_ready, r_busy, r_axi_resetn;
   logic                r_aw_valid, r_w_valid, r_ar_valid;
   logic                r_tx_valid;
   logic [7:0]          r_tx_data;

   logic                w_rx_fire, w_tx_fire, w_b_fire, w_r_fire;
   logic                w_aw_fin, w_w_fin, w_timeout;
   logic [7:0]          w_count_clamped, w_stat_byte;
   logic                w_rx_ready_d, w_b_ready_d, w_r_ready_d, w_busy_d, w_resetn_d;

   assign w_rx_fire = uart_rx_valid && r_rx_ready;
   assign w_tx_fire = r_tx_valid && uart_tx_ready;
   assign w_b_fire  = axi_b_valid && r_b_ready;
   assign w_r_fire  = axi_r_valid && r_r_ready;
   assign w_aw_fin  = !r_aw_valid || axi_aw_ready;
   assign w_w_fin   = !r_w_valid || axi_w_ready;

   assign w_count_clamped = (32'(uart_rx) >= 32'(MAX_BURST)) ? 8'(MAX_BURST - 1) : uart_rx;

   always_comb begin
      w_stat_byte = 8'h4B;
      case (r_stat_sel)
         ST_KE:   w_stat_byte = r_err ? 8'h45 : 8'h4B;
         ST_QM:   w_stat_byte = 8'h3F;
         ST_TO:   w_stat_byte = 8'h54;
         default: w_stat_byte = 8'h4B;
      endcase
   end

`ifdef UART_AXI_TIMEOUT_EN
   // Counts idle cycles while a command is being received; reloads on every byte.
   logic [31:0] r_to_cnt;
   logic        w_rx_phase;
   assign w_rx_phase = (r_state == S_ADDR) || (r_state == S_COUNT) || (r_state == S_WDATA);
   always_ff @(posedge clk) begin
      if (rst || w_rx_fire || !w_rx_phase) r_to_cnt <= 32'd0;
      else                                 r_to_cnt <= r_to_cnt + 32'd1;
   end
   assign w_timeout = w_rx_phase && !w_rx_fire && (r_to_cnt >= 32'(TIMEOUT_CYCLES - 1));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^(32'(TIMEOUT_CYCLES));
   assign w_timeout        = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_rx_fire) begin
            if (uart_rx == OP_W || uart_rx == OP_R) w_state_nxt = S_ADDR;
            else if (uart_rx == OP_X)               w_state_nxt = S_RSTPULSE;
            else                                    w_state_nxt = S_TXSTAT;
         end
         S_ADDR: begin
            if (w_timeout)                             w_state_nxt = S_TXSTAT;
            else if (w_rx_fire && r_cnt == '0)         w_state_nxt = S_COUNT;
         end
         S_COUNT: begin
            if (w_timeout)      w_state_nxt = S_TXSTAT;
            else if (w_rx_fire) w_state_nxt = r_is_wr ? S_WDATA : S_AXI_AR;
         end
         S_WDATA: begin
            if (w_timeout)                     w_state_nxt = S_TXSTAT;
            else if (w_rx_fire && r_cnt == '0) w_state_nxt = S_AXI_W;
         end
         S_AXI_W:    if (w_aw_fin && w_w_fin) w_state_nxt = S_AXI_B;
         S_AXI_B:    if (w_b_fire) w_state_nxt = (r_wleft == 8'd0) ? S_TXSTAT : S_WDATA;
         S_AXI_AR:   if (axi_ar_ready) w_state_nxt = S_AXI_R;
         S_AXI_R:    if (w_r_fire) w_state_nxt = S_TXDATA;
         S_TXDATA:   if (w_tx_fire && r_cnt == '0)
                        w_state_nxt = (r_wleft == 8'd0) ? S_TXSTAT : S_AXI_AR;
         S_TXSTAT:   if (w_tx_fire) w_state_nxt = S_IDLE;
         S_RSTPULSE: if (r_pcnt == '0) w_state_nxt = S_TXSTAT;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // Per-state handshake outputs, registered from the upcoming state
   always_comb begin
      w_rx_ready_d = 1'b0;
      w_b_ready_d  = 1'b0;
      w_r_ready_d  = 1'b0;
      w_busy_d     = 1'b1;
      w_resetn_d   = 1'b1;
      case (w_state_nxt)
         S_IDLE: begin
            w_rx_ready_d = 1'b1;
            w_busy_d     = 1'b0;
         end
         S_ADDR, S_COUNT, S_WDATA: w_rx_ready_d = 1'b1;
         S_AXI_B:    w_b_ready_d = 1'b1;
         S_AXI_R:    w_r_ready_d = 1'b1;
         S_RSTPULSE: w_resetn_d  = 1'b0;
         default:    ;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_sel   <= ST_KE;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rdata_sr   <= '0;
         r_cnt        <= '0;
         r_pcnt       <= '0;
         r_wleft      <= 8'd0;
         r_is_wr      <= 1'b0;
         r_err        <= 1'b0;
         r_rx_ready   <= 1'b0;
         r_b_ready    <= 1'b0;
         r_r_ready    <= 1'b0;
         r_busy       <= 1'b0;
         r_axi_resetn <= 1'b0;
         r_aw_valid   <= 1'b0;
         r_w_valid    <= 1'b0;
         r_ar_valid   <= 1'b0;
         r_tx_valid   <= 1'b0;
         r_tx_data    <= 8'd0;
      end else begin
         r_rx_ready   <= w_rx_ready_d;
         r_b_ready    <= w_b_ready_d;
         r_r_ready    <= w_r_ready_d;
         r_busy       <= w_busy_d;
         r_axi_resetn <= w_resetn_d;
         if (w_timeout) r_stat_sel <= ST_TO;
         case (r_state)
            S_IDLE: if (w_rx_fire) begin
               r_is_wr    <= (uart_rx == OP_W);
               r_cnt      <= CNT_W'(AB - 1);
               r_pcnt     <= PCNT_W'(RST_PULSE - 1);
               r_stat_sel <= (uart_rx == OP_W || uart_rx == OP_R || uart_rx == OP_X) ? ST_KE : ST_QM;
            end
            S_ADDR: if (w_rx_fire) begin
               r_addr <= ADDR_W'({r_addr, uart_rx});
               r_cnt  <= r_cnt - CNT_W'(1);
            end
            S_COUNT: if (w_rx_fire) begin
               r_wleft <= w_count_clamped;
               r_cnt   <= CNT_W'(DB - 1);
            end
            S_WDATA: if (w_rx_fire) begin
               r_wdata <= DATA_W'({r_wdata, uart_rx});
               r_cnt   <= r_cnt - CNT_W'(1);
            end
            S_AXI_W: begin
               if (axi_aw_ready) r_aw_valid <= 1'b0;
               if (axi_w_ready)  r_w_valid  <= 1'b0;
            end
            S_AXI_B: if (w_b_fire) begin
               r_err  <= r_err | (axi_b_resp != 2'b00);
               r_addr <= r_addr + ADDR_W'(1);
               r_cnt  <= CNT_W'(DB - 1);
               if (r_wleft != 8'd0) r_wleft <= r_wleft - 8'd1;
            end
            S_AXI_AR: if (axi_ar_ready) r_ar_valid <= 1'b0;
            S_AXI_R: if (w_r_fire) begin
               r_rdata_sr <= TXW'(axi_r_data);
               r_err      <= r_err | (axi_r_resp != 2'b00);
               r_addr     <= r_addr + ADDR_W'(1);
               r_cnt      <= CNT_W'(DB - 1);
            end
            S_TXDATA: begin
               if (!r_tx_valid) begin
                  r_tx_valid <= 1'b1;
                  r_tx_data  <= r_rdata_sr[TXW-1 -: 8];
               end else if (uart_tx_ready) begin
                  r_tx_valid <= 1'b0;
                  r_rdata_sr <= r_rdata_sr << 8;
                  r_cnt      <= r_cnt - CNT_W'(1);
                  if (r_cnt == '0 && r_wleft != 8'd0) r_wleft <= r_wleft - 8'd1;
               end
            end
            S_TXSTAT: begin
               if (!r_tx_valid) begin
                  r_tx_valid <= 1'b1;
                  r_tx_data  <= w_stat_byte;
               end else if (uart_tx_ready) begin
                  r_tx_valid <= 1'b0;
                  r_err      <= 1'b0;
               end
            end
            S_RSTPULSE: r_pcnt <= r_pcnt - PCNT_W'(1);
            default: ;
         endcase
         // Launch address/data together on entry to the AXI request states
         if (w_state_nxt == S_AXI_W && r_state != S_AXI_W) begin
            r_aw_valid <= 1'b1;
            r_w_valid  <= 1'b1;
         end
         if (w_state_nxt == S_AXI_AR && r_state != S_AXI_AR) r_ar_valid <= 1'b1;
      end
   end

   assign uart_rx_ready = r_rx_ready;
   assign uart_tx       = r_tx_data;
   assign uart_tx_valid = r_tx_valid;
   assign axi_aw_addr   = r_addr;
   assign axi_aw_valid  = r_aw_valid;
   assign axi_w_data    = r_wdata;
   assign axi_w_valid   = r_w_valid;
   assign axi_b_ready   = r_b_ready;
   assign axi_ar_addr   = r_addr;
   assign axi_ar_valid  = r_ar_valid;
   assign axi_r_ready   = r_r_ready;
   assign axi_resetn    = r_axi_resetn;
   assign busy          = r_busy;

endmodule

// File: tb/tb_uart_axi_bridge.sv
// Self-checking bench for uart_axi_bridge: randomised AXI slave, UART sink and memory model.
module tb_uart_axi_bridge;
   localparam int AW = 18;
   localparam int DW = 16;
   localparam int AMASK = (1 << AW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    uart_rx = 8'd0;
   logic          uart_rx_valid = 1'b0;
   logic          uart_rx_ready;
   logic [7:0]    uart_tx;
   logic          uart_tx_valid;
   logic          uart_tx_ready = 1'b0;
   logic [AW-1:0] axi_aw_addr;
   logic          axi_aw_valid;
   logic          axi_aw_ready = 1'b0;
   logic [DW-1:0] axi_w_data;
   logic          axi_w_valid;
   logic          axi_w_ready = 1'b0;
   logic [1:0]    axi_b_resp = 2'd0;
   logic          axi_b_valid = 1'b0;
   logic          axi_b_ready;
   logic [AW-1:0] axi_ar_addr;
   logic          axi_ar_valid;
   logic          axi_ar_ready = 1'b0;
   logic [DW-1:0] axi_r_data = '0;
   logic [1:0]    axi_r_resp = 2'd0;
   logic          axi_r_valid = 1'b0;
   logic          axi_r_ready;
   logic          axi_resetn;
   logic          busy;

   uart_axi_bridge dut (
      .clk(clk), .rst(rst),
      .uart_rx(uart_rx), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
      .uart_tx(uart_tx), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
      .axi_aw_addr(axi_aw_addr), .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
      .axi_w_data(axi_w_data), .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
      .axi_b_resp(axi_b_resp), .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready),
      .axi_ar_addr(axi_ar_addr), .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
      .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp), .axi_r_valid(axi_r_valid),
      .axi_r_ready(axi_r_ready), .axi_resetn(axi_resetn), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct { int a; logic [15:0] d; } wr_t;

   // Reference model: expected memory contents and expected write transactions
   logic [15:0] ref_mem [int];
   wr_t         exp_wr[$];

   // Slave-side state and observations
   logic [15:0] slv_mem [int];
   int          aw_q[$];
   logic [15:0] w_q[$];
   int          ar_q[$];
   wr_t         obs_wr[$];
   int          bresp_q[$];
   int          rresp_q[$];
   bit          hold_wr = 1'b0;
   bit          b_act = 1'b0, r_act = 1'b0;
   int          b_dly = 0, r_dly = 0;
   int          ovl_viol = 0;

   logic [7:0]  tx_q[$];
   bit          tx_stall = 1'b0;

   function automatic logic [15:0] init_word(input int a);
      return 16'((a * 40503) ^ 32'h5A5A);
   endfunction

   function automatic logic [15:0] ref_rd(input int a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_word(a);
   endfunction

   // AXI-lite slave with random ready/response timing
   initial begin : slave
      wr_t w;
      int  ra;
      forever begin
         @(posedge clk);
         if (rst) begin
            aw_q.delete(); w_q.delete(); ar_q.delete();
            b_act = 1'b0; r_act = 1'b0;
         end else begin
            if (axi_ar_valid && (axi_aw_valid || axi_w_valid || b_act || aw_q.size() > 0 || w_q.size() > 0))
               ovl_viol++;
            if ((axi_aw_valid || axi_w_valid) && (r_act || ar_q.size() > 0)) ovl_viol++;
            if (aw_q.size() > 1 || w_q.size() > 1 || ar_q.size() > 1) ovl_viol++;
            if (axi_aw_valid && axi_aw_ready) aw_q.push_back(int'(axi_aw_addr));
            if (axi_w_valid && axi_w_ready)   w_q.push_back(axi_w_data);
            if (axi_ar_valid && axi_ar_ready) ar_q.push_back(int'(axi_ar_addr));
            if (axi_b_valid && axi_b_ready)   b_act = 1'b0;
            if (axi_r_valid && axi_r_ready)   r_act = 1'b0;
         end
         @(negedge clk);
         if (rst) begin
            axi_aw_ready = 1'b0; axi_w_ready = 1'b0; axi_ar_ready = 1'b0;
            axi_b_valid = 1'b0; axi_r_valid = 1'b0;
         end else begin
            axi_aw_ready = !hold_wr && ($urandom_range(0, 2) != 0);
            axi_w_ready  = !hold_wr && ($urandom_range(0, 2) != 0);
            axi_ar_ready = ($urandom_range(0, 2) != 0);
            if (!b_act && aw_q.size() > 0 && w_q.size() > 0) begin
               if (b_dly > 0) b_dly--;
               else begin
                  w.a = aw_q.pop_front();
                  w.d = w_q.pop_front();
                  slv_mem[w.a] = w.d;
                  obs_wr.push_back(w);
                  axi_b_resp = (bresp_q.size() > 0) ? 2'(bresp_q.pop_front()) : 2'd0;
                  b_act = 1'b1;
                  b_dly = $urandom_range(0, 3);
               end
            end
            if (!r_act && ar_q.size() > 0) begin
               if (r_dly > 0) r_dly--;
               else begin
                  ra = ar_q.pop_front();
                  axi_r_data = slv_mem.exists(ra) ? slv_mem[ra] : init_word(ra);
                  axi_r_resp = (rresp_q.size() > 0) ? 2'(rresp_q.pop_front()) : 2'd0;
                  r_act = 1'b1;
                  r_dly = $urandom_range(0, 3);
               end
            end
            axi_b_valid = b_act;
            axi_r_valid = r_act;
         end
      end
   end

   // UART transmit sink: random ready, collects bytes, checks valid/data hold
   initial begin : tx_sink
      bit         pend = 1'b0;
      logic [7:0] last = 8'd0;
      forever begin
         @(posedge clk);
         if (rst) pend = 1'b0;
         else begin
            if (pend && (!uart_tx_valid || uart_tx !== last)) ovl_viol++;
            if (uart_tx_valid && uart_tx_ready) begin
               tx_q.push_back(uart_tx);
               pend = 1'b0;
            end else begin
               pend = uart_tx_valid;
               last = uart_tx;
            end
         end
         @(negedge clk);
         uart_tx_ready = !tx_stall && !rst && ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      uart_rx = b;
      uart_rx_valid = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!uart_rx_ready && n < 2000);
      if (!uart_rx_ready) begin
         total++; bad++;
         $display("FAIL rx_accept: byte %02h not taken after %0d cycles", b, n);
      end
      @(negedge clk);
      uart_rx_valid = 1'b0;
   endtask

   task automatic wait_tx(input int n, output bit ok);
      int c = 0;
      while (tx_q.size() < n && c < 5000) begin
         @(negedge clk);
         c++;
      end
      ok = (tx_q.size() >= n);
   endtask

   task automatic wait_idle();
      int c = 0;
      while ((busy || uart_rx_ready !== 1'b1) && c < 5000) begin
         @(negedge clk);
         c++;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic do_write(input int a, input logic [15:0] d[$]);
      logic [23:0] ab;
      wr_t         w;
      ab = 24'(a);
      send_byte(8'h57);
      send_byte(ab[23:16]); send_byte(ab[15:8]); send_byte(ab[7:0]);
      send_byte(8'(d.size() - 1));
      for (int i = 0; i < d.size(); i++) begin
         send_byte(d[i][15:8]);
         send_byte(d[i][7:0]);
         w.a = (a + i) & AMASK;
         w.d = d[i];
         ref_mem[w.a] = d[i];
         exp_wr.push_back(w);
      end
   endtask

   task automatic do_read(input int a, input int nw);
      logic [23:0] ab;
      ab = 24'(a);
      send_byte(8'h52);
      send_byte(ab[23:16]); send_byte(ab[15:8]); send_byte(ab[7:0]);
      send_byte(8'(nw - 1));
   endtask

   task automatic clear_obs();
      tx_q.delete(); obs_wr.delete(); exp_wr.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({axi_aw_valid, axi_w_valid, axi_ar_valid, uart_tx_valid, uart_rx_ready,
           axi_b_ready, axi_r_ready, busy, axi_resetn} !== 9'd0) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 000000000", {axi_aw_valid, axi_w_valid,
                  axi_ar_valid, uart_tx_valid, uart_rx_ready, axi_b_ready, axi_r_ready, busy, axi_resetn});
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({axi_resetn, uart_rx_ready, busy} !== 3'b110) begin
         bad++;
         $display("FAIL post_reset: got resetn/rx_ready/busy=%b want 110", {axi_resetn, uart_rx_ready, busy});
      end
   endtask

   task automatic test_write_read();
      bit          ok;
      logic [7:0]  exp_b[5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h4B};
      logic [15:0] d[$] = '{16'h1234, 16'h5678};
      clear_obs();
      do_write(32'h10, d);
      wait_tx(1, ok);
      wait_idle();
      total++;
      if (obs_wr.size() !== 2 || !ok) begin
         bad++;
         $display("FAIL wr_count: got %0d writes/%0d tx want 2/1", obs_wr.size(), tx_q.size());
      end else begin
         total++;
         if (obs_wr[0].a !== 32'h10 || obs_wr[0].d !== 16'h1234 || obs_wr[1].a !== 32'h11 || obs_wr[1].d !== 16'h5678) begin
            bad++;
            $display("FAIL wr_data: got %05h/%04h %05h/%04h want 00010/1234 00011/5678",
                     obs_wr[0].a, obs_wr[0].d, obs_wr[1].a, obs_wr[1].d);
         end
         total++;
         if (tx_q[0] !== 8'h4B) begin bad++; $display("FAIL wr_status: got %02h want 4b", tx_q[0]); end
      end
      clear_obs();
      do_read(32'h10, 2);
      wait_tx(5, ok);
      wait_idle();
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL rd_count: got %0d bytes want 5", tx_q.size());
      end else
         for (int i = 0; i < 5; i++) begin
            total++;
            if (tx_q[i] !== exp_b[i]) begin
               bad++;
               $display("FAIL rd_byte%0d: got %02h want %02h", i, tx_q[i], exp_b[i]);
            end
         end
   endtask

   task automatic test_wrap();
      bit          ok;
      logic [15:0] d[$] = '{16'hAAAA, 16'hBBBB};
      clear_obs();
      do_write(32'h3FFFF, d);
      wait_tx(1, ok);
      wait_idle();
      total++;
      if (!ok || obs_wr.size() !== 2) begin
         bad++;
         $display("FAIL wrap_count: got %0d writes want 2", obs_wr.size());
      end else begin
         total++;
         if (obs_wr[0].a !== 32'h3FFFF || obs_wr[1].a !== 0 || obs_wr[1].d !== 16'hBBBB) begin
            bad++;
            $display("FAIL wrap_addr: got %05h %05h/%04h want 3ffff 00000/bbbb", obs_wr[0].a, obs_wr[1].a, obs_wr[1].d);
         end
         total++;
         if (tx_q[0] !== 8'h4B) begin bad++; $display("FAIL wrap_status: got %02h want 4b", tx_q[0]); end
      end
   endtask

   task automatic test_error();
      bit          ok;
      logic [15:0] d[$] = '{16'hC0DE, 16'hBEEF};
      clear_obs();
      bresp_q.push_back(2);
      do_write(32'h400, d);
      wait_tx(1, ok);
      wait_idle();
      total++;
      if (!ok || obs_wr.size() !== 2 || tx_q[0] !== 8'h45) begin
         bad++;
         $display("FAIL berr: got %0d writes status %02h want 2 writes status 45",
                  obs_wr.size(), ok ? tx_q[0] : 8'hxx);
      end
      clear_obs();
      do_read(32'h401, 1);
      wait_tx(3, ok);
      wait_idle();
      total++;
      if (!ok || {tx_q[0], tx_q[1], tx_q[2]} !== {16'hBEEF, 8'h4B}) begin
         bad++;
         $display("FAIL clean_after_err: got %0d bytes want beef4b", tx_q.size());
      end
      clear_obs();
      rresp_q.push_back(2);
      do_read(32'h400, 1);
      wait_tx(3, ok);
      wait_idle();
      total++;
      if (!ok || {tx_q[0], tx_q[1], tx_q[2]} !== {16'hC0DE, 8'h45}) begin
         bad++;
         $display("FAIL rerr: got %0d bytes want c0de45", tx_q.size());
      end
   endtask

   task automatic test_unknown_reset();
      bit ok;
      int low = 0;
      clear_obs();
      send_byte(8'h41);
      wait_tx(1, ok);
      wait_idle();
      total++;
      if (!ok || tx_q[0] !== 8'h3F) begin
         bad++;
         $display("FAIL unknown_op: got %0d bytes want 3f", tx_q.size());
      end
      clear_obs();
      send_byte(8'h58);
      for (int i = 0; i < 40; i++) begin
         if (!axi_resetn) low++;
         @(negedge clk);
      end
      wait_tx(1, ok);
      wait_idle();
      total++;
      if (low !== 16) begin bad++; $display("FAIL xpulse_len: got %0d want 16", low); end
      total++;
      if (!ok || tx_q[0] !== 8'h4B) begin
         bad++;
         $display("FAIL x_status: got %0d bytes want 4b", tx_q.size());
      end
   endtask

   task automatic test_random_bursts();
      bit          ok;
      int          a, n;
      logic [15:0] d[$];
      for (int it = 0; it < 8; it++) begin
         a = (it == 0) ? AMASK - 1 : int'($urandom_range(0, AMASK));
         n = $urandom_range(1, 6);
         d.delete();
         for (int i = 0; i < n; i++) d.push_back(16'($urandom));
         clear_obs();
         do_write(a, d);
         wait_tx(1, ok);
         wait_idle();
         total++;
         if (!ok || obs_wr.size() !== exp_wr.size() || tx_q[0] !== 8'h4B) begin
            bad++;
            $display("FAIL rnd_wr%0d: got %0d writes want %0d", it, obs_wr.size(), exp_wr.size());
         end else
            for (int i = 0; i < n; i++) begin
               total++;
               if (obs_wr[i].a !== exp_wr[i].a || obs_wr[i].d !== exp_wr[i].d) begin
                  bad++;
                  $display("FAIL rnd_wr%0d_%0d: got %05h/%04h want %05h/%04h", it, i,
                           obs_wr[i].a, obs_wr[i].d, exp_wr[i].a, exp_wr[i].d);
               end
            end
         clear_obs();
         n = $urandom_range(1, 6);
         do_read(a, n);
         wait_tx(2 * n + 1, ok);
         wait_idle();
         total++;
         if (!ok || tx_q.size() !== 2 * n + 1 || tx_q[2 * n] !== 8'h4B) begin
            bad++;
            $display("FAIL rnd_rd%0d: got %0d bytes want %0d", it, tx_q.size(), 2 * n + 1);
         end else
            for (int i = 0; i < n; i++) begin
               total++;
               if ({tx_q[2 * i], tx_q[2 * i + 1]} !== ref_rd((a + i) & AMASK)) begin
                  bad++;
                  $display("FAIL rnd_rd%0d_%0d: got %02h%02h want %04h", it, i,
                           tx_q[2 * i], tx_q[2 * i + 1], ref_rd((a + i) & AMASK));
               end
            end
      end
   endtask

   task automatic test_stall();
      bit          ok;
      int          a;
      logic [15:0] d[$];
      a = int'($urandom_range(0, AMASK));
      for (int i = 0; i < 4; i++) d.push_back(16'($urandom));
      clear_obs();
      do_write(a, d);
      wait_tx(1, ok);
      wait_idle();
      clear_obs();
      tx_stall = 1'b1;
      do_read(a, 4);
      repeat (200) @(negedge clk);
      total++;
      if (tx_q.size() !== 0) begin bad++; $display("FAIL stall_leak: got %0d bytes want 0", tx_q.size()); end
      tx_stall = 1'b0;
      wait_tx(9, ok);
      wait_idle();
      total++;
      if (!ok || tx_q.size() !== 9 || tx_q[8] !== 8'h4B) begin
         bad++;
         $display("FAIL stall_count: got %0d bytes want 9", tx_q.size());
      end else
         for (int i = 0; i < 4; i++) begin
            total++;
            if ({tx_q[2 * i], tx_q[2 * i + 1]} !== ref_rd((a + i) & AMASK)) begin
               bad++;
               $display("FAIL stall_word%0d: got %02h%02h want %04h", i, tx_q[2 * i], tx_q[2 * i + 1],
                        ref_rd((a + i) & AMASK));
            end
         end
      total++;
      if (ovl_viol !== 0) begin bad++; $display("FAIL protocol: got %0d violations want 0", ovl_viol); end
   endtask

   task automatic test_midop_reset();
      bit          ok;
      int          c = 0;
      logic [15:0] d[$] = '{16'h5A5A};
      clear_obs();
      hold_wr = 1'b1;
      send_byte(8'h57); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h00); send_byte(8'h99); send_byte(8'h88);
      while (!axi_aw_valid && c < 100) begin @(negedge clk); c++; end
      total++;
      if (axi_aw_valid !== 1'b1) begin bad++; $display("FAIL midop_aw: got %b want 1", axi_aw_valid); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({axi_aw_valid, axi_w_valid, busy, axi_resetn} !== 4'b0000) begin
         bad++;
         $display("FAIL midop_clear: got aw/w/busy/resetn=%b want 0000", {axi_aw_valid, axi_w_valid, busy, axi_resetn});
      end
      hold_wr = 1'b0;
      repeat (3) @(negedge clk);
      clear_obs();
      do_write(32'h200, d);
      wait_tx(1, ok);
      wait_idle();
      clear_obs();
      do_read(32'h200, 1);
      wait_tx(3, ok);
      wait_idle();
      total++;
      if (!ok || {tx_q[0], tx_q[1], tx_q[2]} !== {16'h5A5A, 8'h4B}) begin
         bad++;
         $display("FAIL after_reset: got %0d bytes want 5a5a4b", tx_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_wrap();
      test_error();
      test_unknown_reset();
      test_random_bursts();
      test_stall();
      test_midop_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
